// File: rtl/mpeg_mv_pkg.sv
// Shared types and limits for the MPEG motion-vector decode path.
package mpeg_mv_pkg;

  typedef enum logic [1:0] {IDLE, RESID, CALC, DONE} mv_state_t;

  localparam int F_CODE_MIN   = 1;
  localparam int F_CODE_MAX   = 9;
  localparam int MAX_R_SIZE   = 8;
  localparam int MV_W_DEFAULT = 13;

endpackage

// File: rtl/mv_wrap_calc.sv
// Combinational motion-vector reconstruction against a predictor with modulo
// wrap into [-lim, lim-1], lim = 16 << r_size.
module mv_wrap_calc
  import mpeg_mv_pkg::*;
#(
  parameter int MV_W = MV_W_DEFAULT
) (
  input  logic signed [MV_W-1:0]       pmv,
  input  logic signed [4:0]            mcode,
  input  logic        [MAX_R_SIZE-1:0] residual,
  input  logic        [3:0]            r_size,
  output logic signed [MV_W-1:0]       v
);

  // One guard bit keeps the pre-wrap sum exact for every legal operand.
  localparam int W = MV_W + 1;

  logic signed [W-1:0] pmv_x;
  logic signed [W-1:0] mc_x;
  logic signed [W-1:0] mag;
  logic signed [W-1:0] base;
  logic signed [W-1:0] res_x;
  logic signed [W-1:0] lim;
  logic signed [W-1:0] sum_pos;
  logic signed [W-1:0] sum_neg;
  logic signed [W-1:0] v_w;

  assign pmv_x   = {pmv[MV_W-1], pmv};
  assign mc_x    = {{(W-5){mcode[4]}}, mcode};
  assign mag     = mcode[4] ? -mc_x : mc_x;
  assign base    = (mag - W'(1)) << r_size;
  assign res_x   = {{(W-MAX_R_SIZE){1'b0}}, residual};
  assign lim     = W'(16) << r_size;
  assign sum_pos = pmv_x + base + res_x + W'(1);
  assign sum_neg = pmv_x - base - res_x - W'(1);

  always_comb begin
    v_w = pmv_x;
    if (mcode[4]) begin
      v_w = (sum_neg < -lim) ? sum_neg + (lim << 1) : sum_neg;
    end else if (mcode != 5'd0) begin
      v_w = (sum_pos >= lim) ? sum_pos - (lim << 1) : sum_pos;
    end
  end

  assign v = v_w[MV_W-1:0];

endmodule

// File: rtl/motion_vector_decode.sv
// Motion-vector component decoder: accepts a motion_code, pulls the residual
// from the bitstream window and reconstructs the vector against the held PMV.
module motion_vector_decode
  import mpeg_mv_pkg::*;
#(
  parameter int MV_W  = MV_W_DEFAULT,
  parameter int WIN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mc_valid,
  input  logic signed [4:0]      mcode,
  input  logic        [3:0]      f_code,
  output logic                   ready,
  input  logic        [WIN_W-1:0] bits,
  input  logic                   bits_valid,
  output logic                   shift_valid,
  output logic        [3:0]      shift_amt,
  input  logic                   pmv_clear,
  output logic                   mv_valid,
  output logic signed [MV_W-1:0] mv,
  output logic                   mv_err,
  output logic signed [MV_W-1:0] pmv
);

  mv_state_t state;
  mv_state_t state_next;

  logic signed [4:0]            mcode_q;
  logic        [3:0]            r_size_q;
  logic                         err_q;
  logic        [MAX_R_SIZE-1:0] residual_q;

  logic        [3:0]            r_size_in;
  logic                         f_err;
  logic        [WIN_W-1:0]      bits_top;
  logic        [MAX_R_SIZE-1:0] resid_in;
  logic signed [MV_W-1:0]       calc_v;
  logic signed [MV_W-1:0]       v;

  assign r_size_in = f_code - 4'd1;
  assign f_err     = (f_code < 4'(F_CODE_MIN)) || (f_code > 4'(F_CODE_MAX));
  assign bits_top  = bits >> (WIN_W - int'(r_size_q));
  assign resid_in  = bits_top[MAX_R_SIZE-1:0];

  mv_wrap_calc #(.MV_W(MV_W)) u_calc (
    .pmv      (pmv),
    .mcode    (mcode_q),
    .residual (residual_q),
    .r_size   (r_size_q),
    .v        (calc_v)
  );

  assign v = err_q ? pmv : calc_v;

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    shift_valid = 1'b0;
    shift_amt   = 4'd0;
    mv_valid    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (mc_valid) begin
          if (f_err || mcode == 5'd0 || r_size_in == 4'd0) state_next = CALC;
          else state_next = RESID;
        end
      end
      RESID: begin
        if (bits_valid) begin
          shift_valid = 1'b1;
          shift_amt   = r_size_q;
          state_next  = CALC;
        end
      end
      CALC:    state_next = DONE;
      DONE: begin
        mv_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle must never leak a consume or result pulse.
    if (rst) begin
      shift_valid = 1'b0;
      shift_amt   = 4'd0;
      mv_valid    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcode_q    <= '0;
      r_size_q   <= '0;
      err_q      <= 1'b0;
      residual_q <= '0;
      mv         <= '0;
      mv_err     <= 1'b0;
      pmv        <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && mc_valid) begin
        mcode_q    <= mcode;
        r_size_q   <= r_size_in;
        err_q      <= f_err;
        residual_q <= '0;
      end
      if (shift_valid) residual_q <= resid_in;
      if (state == CALC) begin
        mv     <= v;
        mv_err <= err_q;
      end
      // Clear wins over a same-cycle predictor update.
      if (pmv_clear) pmv <= '0;
      else if (state == CALC) pmv <= v;
    end
  end

endmodule

// File: doc/motion_vector_decode.md
Name: motion_vector_decode

Overview:
- Downstream of get_motion_code in the MPEG motion-vector path.
- Accepts one signed motion_code per handshake and pulls the motion_residual (r_size = f_code-1 bits) from the bitstream window, MSB first.
- Reconstructs the vector against a held predictor (PMV) using modulo wrap, updates the PMV, and emits the vector with a one-cycle valid pulse.
- One instance per vector component (horizontal or vertical); full_pel vectors are not supported.

Parameters:
- MV_W, 13: vector/PMV width, signed; covers -4096..4095 (f_code 9).
- WIN_W, 8: width of the bitstream window; must be >= 8, the maximum r_size.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- mc_valid  input  1  mcode is valid; accepted only when ready=1.
- mcode  input  5  signed motion_code from get_motion_code, range -16..15.
- f_code  input  4  sampled together with mcode; legal values 1..9.
- ready  output  1  high in IDLE.
- bits  input  WIN_W  bitstream window; bits[WIN_W-1] is the next bit.
- bits_valid  input  1  window contents are valid this cycle.
- shift_valid  output  1  one-cycle pulse: upstream must consume shift_amt bits.
- shift_amt  output  4  number of residual bits consumed; 0 when shift_valid=0.
- pmv_clear  input  1  forces PMV to 0 (slice start, intra MB).
- mv_valid  output  1  one-cycle pulse; mv and mv_err are valid.
- mv  output  MV_W  signed reconstructed vector; holds its value until the next mv_valid.
- mv_err  output  1  f_code was illegal; qualified by mv_valid.
- pmv  output  MV_W  current predictor.

Behaviour:
- Reset values: ready=1, shift_valid=0, shift_amt=0, mv_valid=0, mv=0, mv_err=0, pmv=0, state=IDLE.
- Reset taken in any state aborts the operation immediately: no shift_valid and no mv_valid are emitted afterwards.
- FSM states: IDLE, RESID, CALC, DONE.
- IDLE:
  - On mc_valid, latch mcode and f_code, and set r_size = f_code-1.
  - If f_code is 0 or >9: set err, go to CALC.
  - Else if mcode==0 or r_size==0: residual=0, go to CALC.
  - Else go to RESID.
- RESID:
  - Wait while bits_valid=0.
  - When bits_valid=1: residual = top r_size bits of bits; pulse shift_valid=1 with shift_amt=r_size for exactly that cycle; go to CALC.
- CALC, with lim = 16<<r_size and all arithmetic signed at MV_W+1 bits:
  - mcode>0: v = pmv + ((mcode-1)<<r_size) + residual + 1; if v >= lim then v -= 2*lim.
  - mcode<0: v = pmv - (((-mcode)-1)<<r_size) - residual - 1; if v < -lim then v += 2*lim.
  - mcode==0: v = pmv.
  - err: v = pmv.
  - Register mv=v, pmv=v, mv_err=err; go to DONE.
- DONE: mv_valid=1 for one cycle; go to IDLE. ready rises the next cycle.
- Latency from the accept cycle T:
  - no residual: mv_valid at T+2.
  - with residual: mv_valid 2 cycles after the bits_valid cycle.
  - Throughput: one vector per 3 cycles minimum.
- pmv_clear:
  - Honoured in any state and overrides a same-cycle CALC update of pmv (pmv=0).
  - mv still shows the computed value.
- mc_valid while ready=0 is ignored; upstream must hold it.
- mcode=-16 is legal and is treated as magnitude 16.

Decomposition:
- Shared package mpeg_mv_pkg holds:
  - state enum {IDLE, RESID, CALC, DONE};
  - F_CODE_MIN=1, F_CODE_MAX=9, MAX_R_SIZE=8;
  - MV_W default.
- One natural sub-module, mv_wrap_calc: purely combinational (pmv, mcode, residual, r_size) -> v. It can be unit-tested separately and reused for the vertical/field paths.

Test Plan:
- f_code=1, pmv=0, mcode=3 -> no shift_valid; mv_valid at T+2; mv=3, pmv=3.
- f_code=1, pmv=14, mcode=3 -> v=17 >= 16; mv=-15, mv_err=0.
- f_code=3, pmv=0, mcode=-2, bits=8'b10xxxxxx with bits_valid delayed 3 cycles -> shift_valid with shift_amt=2 only on the bits_valid cycle; mv=-7.
- f_code=3, pmv=-60, mcode=-2, bits=8'b11xxxxxx -> v=-68 < -64; mv=60.
- f_code=0, mcode=5, pmv=9 -> no shift_valid; mv=9, mv_err=1; a back-to-back mc_valid during busy is ignored until ready.
- Cases for rst and pmv_clear:
  - pmv_clear asserted in the CALC cycle of pmv=5, mcode=1, f_code=1 -> mv=6, pmv=0.
  - rst asserted in RESID -> no shift_valid, no mv_valid, all outputs return to reset values next cycle.
